// File: rtl/ip_bus_initiator.sv
// -----------------------------------------------------------------------------
// ip_bus_initiator
//
// Initiator for the internal one-cycle-strobe slot bus shared by the cartridge
// IP responders. One request is taken over a valid/ready handshake. Each request
// produces exactly one memory or I/O strobe. Reads then wait, for a bounded time,
// for the responder's read-ready pulse. Every access ends with a single-cycle
// completion pulse, followed by a fixed idle gap before the next request is
// accepted.
//
// Parameters
//   TIMEOUT_CYCLES  read-wait cycles without bus_read_ready before timeout (1..255)
//   GAP_CYCLES      idle cycles after each access before the next accept (0..15)
//
// Ports
//   n_reset          in   async active-low reset
//   clk              in   system clock, rising edge
//   req_valid        in   request present
//   req_ready        out  initiator idle, can accept (decoded from state)
//   req_write        in   1 = write, 0 = read
//   req_memory       in   1 = memory space, 0 = I/O space
//   req_address      in   [15:0] access address
//   req_wdata        in   [7:0] write data
//   resp_valid       out  one-cycle completion pulse (reads and writes)
//   resp_rdata       out  [7:0] read data, valid with resp_valid
//   resp_timeout     out  read timed out, valid with resp_valid
//   bus_address      out  [15:0] strobe address, 0 outside the strobe cycle
//   bus_write_data   out  [7:0] strobe write data, 0 outside a write strobe
//   bus_read         out  read strobe
//   bus_write        out  write strobe
//   bus_memory       out  memory-space qualifier of the strobe
//   bus_read_ready   in   responder read-data-valid pulse
//   bus_read_data    in   [7:0] responder data
// -----------------------------------------------------------------------------
module ip_bus_initiator #(
   parameter int unsigned TIMEOUT_CYCLES = 100,
   parameter int unsigned GAP_CYCLES     = 3
) (
   input  logic        n_reset,
   input  logic        clk,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic        req_memory,
   input  logic [15:0] req_address,
   input  logic [7:0]  req_wdata,
   output logic        resp_valid,
   output logic [7:0]  resp_rdata,
   output logic        resp_timeout,
   output logic [15:0] bus_address,
   output logic [7:0]  bus_write_data,
   output logic        bus_read,
   output logic        bus_write,
   output logic        bus_memory,
   input  logic        bus_read_ready,
   input  logic [7:0]  bus_read_data
);

   localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);
   localparam logic [3:0] GAP_LEN   = 4'(GAP_CYCLES);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_STROBE = 3'd1,
      S_WAIT   = 3'd2,
      S_RESP   = 3'd3,
      S_GAP    = 3'd4
   } state_t;

   state_t      state_q;
   logic        wr_q;            // latched request direction
   logic [7:0]  wait_cnt_q;      // sampled read-wait cycles without ready
   logic [7:0]  wait_cnt_d;
   logic [3:0]  gap_cnt_q;       // remaining GAP cycles minus one

   // Responder handshake is registered once before the FSM acts on it. This
   // puts the response one cycle after the sampling edge and keeps the
   // responder's combinational path away from the state logic.
   logic        smp_rdy_q;
   logic [7:0]  smp_data_q;

   logic        resp_valid_q;
   logic [7:0]  resp_rdata_q;
   logic        resp_timeout_q;
   logic [15:0] bus_address_q;
   logic [7:0]  bus_write_data_q;
   logic        bus_read_q;
   logic        bus_write_q;
   logic        bus_memory_q;

   logic        sample_en;

   assign wait_cnt_d = wait_cnt_q + 8'd1;

   // bus_read_ready counts only from the strobe cycle through the read wait;
   // stray pulses in any other state are dropped here.
   assign sample_en = (state_q == S_STROBE) || (state_q == S_WAIT);

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state_q          <= S_IDLE;
         wr_q             <= 1'b0;
         wait_cnt_q       <= 8'd0;
         gap_cnt_q        <= 4'd0;
         smp_rdy_q        <= 1'b0;
         smp_data_q       <= 8'h00;
         resp_valid_q     <= 1'b0;
         resp_rdata_q     <= 8'h00;
         resp_timeout_q   <= 1'b0;
         bus_address_q    <= 16'h0000;
         bus_write_data_q <= 8'h00;
         bus_read_q       <= 1'b0;
         bus_write_q      <= 1'b0;
         bus_memory_q     <= 1'b0;
      end else begin
         // completion is a pulse; only the transition into RESP raises it
         resp_valid_q <= 1'b0;

         smp_rdy_q <= sample_en & bus_read_ready;
         if (sample_en && bus_read_ready) begin
            smp_data_q <= bus_read_data;
         end

         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  state_q          <= S_STROBE;
                  wr_q             <= req_write;
                  wait_cnt_q       <= 8'd0;
                  bus_address_q    <= req_address;
                  bus_write_data_q <= req_write ? req_wdata : 8'h00;
                  bus_write_q      <= req_write;
                  bus_read_q       <= ~req_write;
                  bus_memory_q     <= req_memory;
               end
            end

            S_STROBE: begin
               // strobe lasts exactly one cycle
               bus_address_q    <= 16'h0000;
               bus_write_data_q <= 8'h00;
               bus_write_q      <= 1'b0;
               bus_read_q       <= 1'b0;
               bus_memory_q     <= 1'b0;
               if (wr_q) begin
                  state_q        <= S_RESP;
                  resp_valid_q   <= 1'b1;
                  resp_timeout_q <= 1'b0;
               end else begin
                  state_q <= S_WAIT;
               end
            end

            S_WAIT: begin
               // smp_rdy_q holds the sample taken one edge earlier. Data is
               // checked first so a ready on the final sample beats the timeout.
               if (smp_rdy_q) begin
                  state_q        <= S_RESP;
                  resp_valid_q   <= 1'b1;
                  resp_rdata_q   <= smp_data_q;
                  resp_timeout_q <= 1'b0;
               end else if (wait_cnt_d == TMO_LIMIT) begin
                  state_q        <= S_RESP;
                  resp_valid_q   <= 1'b1;
                  resp_rdata_q   <= 8'hFF;   // open bus
                  resp_timeout_q <= 1'b1;
               end else begin
                  wait_cnt_q <= wait_cnt_d;
               end
            end

            S_RESP: begin
               if (GAP_LEN == 4'd0) begin
                  state_q <= S_IDLE;
               end else begin
                  state_q   <= S_GAP;
                  gap_cnt_q <= GAP_LEN - 4'd1;
               end
            end

            S_GAP: begin
               if (gap_cnt_q == 4'd0) begin
                  state_q <= S_IDLE;
               end else begin
                  gap_cnt_q <= gap_cnt_q - 4'd1;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready      = (state_q == S_IDLE);
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = resp_rdata_q;
   assign resp_timeout   = resp_timeout_q;
   assign bus_address    = bus_address_q;
   assign bus_write_data = bus_write_data_q;
   assign bus_read       = bus_read_q;
   assign bus_write      = bus_write_q;
   assign bus_memory     = bus_memory_q;

endmodule

// File: tb/tb_ip_bus_initiator.sv
module tb_ip_bus_initiator;
   localparam int T   = 10;
   localparam int GAP = 3;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_write = 1'b0;
   logic        req_memory = 1'b0;
   logic [15:0] req_address = 16'h0000;
   logic [7:0]  req_wdata = 8'h00;
   logic        resp_valid;
   logic [7:0]  resp_rdata;
   logic        resp_timeout;
   logic [15:0] bus_address;
   logic [7:0]  bus_write_data;
   logic        bus_read;
   logic        bus_write;
   logic        bus_memory;
   logic        bus_read_ready = 1'b0;
   logic [7:0]  bus_read_data = 8'h00;

   always #5 clk = ~clk;

   ip_bus_initiator #(.TIMEOUT_CYCLES(T), .GAP_CYCLES(GAP)) dut (
      .n_reset(n_reset), .clk(clk),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_memory(req_memory), .req_address(req_address), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_timeout(resp_timeout),
      .bus_address(bus_address), .bus_write_data(bus_write_data),
      .bus_read(bus_read), .bus_write(bus_write), .bus_memory(bus_memory),
      .bus_read_ready(bus_read_ready), .bus_read_data(bus_read_data)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------
   // Timestamp model: each access is an accept edge plus computed edges at
   // which the response pulses and at which the initiator is free again.
   // ---------------------------------------------------------------------
   int          m_cyc = 0;
   int          m_acc = -1;
   int          m_resp_edge = -1;
   int          m_ready_edge = -1;
   bit          m_idle = 1'b1;
   bit          m_decided = 1'b1;
   logic [7:0]  m_rdata = 8'h00;
   logic        m_tmo = 1'b0;

   logic        e_ready = 1'b1;
   logic        e_resp_valid = 1'b0;
   logic [7:0]  e_rdata = 8'h00;
   logic        e_tmo = 1'b0;
   logic [15:0] e_addr = 16'h0000;
   logic [7:0]  e_wdata = 8'h00;
   logic        e_rd = 1'b0;
   logic        e_wr = 1'b0;
   logic        e_mem = 1'b0;

   always @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         m_idle = 1'b1; m_decided = 1'b1;
         m_acc = -1; m_resp_edge = -1; m_ready_edge = -1;
         e_ready = 1'b1; e_resp_valid = 1'b0; e_rdata = 8'h00; e_tmo = 1'b0;
         e_addr = 16'h0000; e_wdata = 8'h00; e_rd = 1'b0; e_wr = 1'b0; e_mem = 1'b0;
      end else begin
         m_cyc = m_cyc + 1;
         e_resp_valid = 1'b0;
         e_addr = 16'h0000; e_wdata = 8'h00; e_rd = 1'b0; e_wr = 1'b0; e_mem = 1'b0;
         if (m_idle && req_valid) begin
            m_idle = 1'b0;
            m_acc  = m_cyc;
            e_addr = req_address;
            e_wdata = req_write ? req_wdata : 8'h00;
            e_wr = req_write; e_rd = ~req_write; e_mem = req_memory;
            if (req_write) begin
               m_decided = 1'b1; m_resp_edge = m_cyc + 1;
               m_rdata = e_rdata; m_tmo = 1'b0;
            end else begin
               m_decided = 1'b0;
            end
         end else if (!m_decided) begin
            // sample number (m_cyc - m_acc) counts from 1 at the strobe cycle
            if (bus_read_ready) begin
               m_decided = 1'b1; m_resp_edge = m_cyc + 1;
               m_rdata = bus_read_data; m_tmo = 1'b0;
            end else if (m_cyc - m_acc == T) begin
               m_decided = 1'b1; m_resp_edge = m_cyc + 1;
               m_rdata = 8'hFF; m_tmo = 1'b1;
            end
         end
         if (m_cyc == m_resp_edge) begin
            e_resp_valid = 1'b1; e_rdata = m_rdata; e_tmo = m_tmo;
            m_ready_edge = m_cyc + 1 + GAP;
         end
         if (m_cyc == m_ready_edge) m_idle = 1'b1;
         e_ready = m_idle;
      end
   end

   bit chk_en = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready", 32'(req_ready), 32'(e_ready));
         chk("resp_valid", 32'(resp_valid), 32'(e_resp_valid));
         chk("bus_address", 32'(bus_address), 32'(e_addr));
         chk("bus_write_data", 32'(bus_write_data), 32'(e_wdata));
         chk("bus_strobes", 32'({bus_read, bus_write, bus_memory}), 32'({e_rd, e_wr, e_mem}));
         if (e_resp_valid) begin
            chk("resp_rdata", 32'(resp_rdata), 32'(e_rdata));
            chk("resp_timeout", 32'(resp_timeout), 32'(e_tmo));
         end
      end
   end

   int resp_cnt = 0;
   always @(negedge clk) if (resp_valid) resp_cnt++;

   int tb_cyc = 0;
   always @(posedge clk) tb_cyc <= tb_cyc + 1;

   // Issue one request (caller is at posedge+1 with the initiator idle),
   // optionally pulse bus_read_ready on sample k, and measure the response.
   task automatic run(input logic w, input logic m, input logic [15:0] a, input logic [7:0] wd,
                      input int k, input logic [7:0] rdat,
                      output int lat, output logic [7:0] rd, output logic tmo,
                      output logic [26:0] snap);
      int l;
      logic [7:0] r;
      logic t;
      req_valid = 1'b1; req_write = w; req_memory = m; req_address = a; req_wdata = wd;
      @(posedge clk); #1;
      req_valid = 1'b0; req_write = ~w; req_memory = ~m; req_address = ~a; req_wdata = ~wd;
      snap = {bus_address, bus_write_data, bus_read, bus_write, bus_memory};
      l = -1; r = 8'h00; t = 1'b0;
      fork
         begin
            if (k > 0) begin
               repeat (k - 1) @(posedge clk);
               #1;
               bus_read_ready = 1'b1; bus_read_data = rdat;
               @(posedge clk); #1;
               bus_read_ready = 1'b0; bus_read_data = 8'h00;
            end
         end
         begin
            for (int i = 1; i <= 40 && l < 0; i++) begin
               @(posedge clk); #1;
               if (resp_valid) begin l = i; r = resp_rdata; t = resp_timeout; end
            end
         end
      join
      lat = l; rd = r; tmo = t;
   endtask

   task automatic settle();
      repeat (GAP + 2) @(posedge clk);
      #1;
   endtask

   int          lat;
   logic [7:0]  rd;
   logic        tmo;
   logic [26:0] snap;
   int          c0;
   int          acc_t [3];
   logic        mem_s [3];

   initial begin
      #1 chk_en = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp", 32'({resp_valid, resp_timeout, resp_rdata}), 32'd0);
      chk("rst_bus", 32'({bus_address, bus_write_data, bus_read, bus_write, bus_memory}), 32'd0);
      n_reset = 1'b1;
      @(posedge clk); #1;

      // memory write 9800/55
      run(1'b1, 1'b1, 16'h9800, 8'h55, 0, 8'h00, lat, rd, tmo, snap);
      chk("wr_strobe", 32'(snap), 32'({16'h9800, 8'h55, 1'b0, 1'b1, 1'b1}));
      chk("wr_lat", 32'(lat), 32'd1);
      chk("wr_tmo", 32'(tmo), 32'd0);
      chk("wr_rdata_kept", 32'(rd), 32'h00);
      repeat (3) @(posedge clk); #1;
      chk("wr_ready_A4", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk("wr_ready_A5", 32'(req_ready), 32'd1);

      // read, ready on sample 5
      run(1'b0, 1'b1, 16'h4000, 8'h99, 5, 8'hA5, lat, rd, tmo, snap);
      chk("rd_strobe", 32'(snap), 32'({16'h4000, 8'h00, 1'b1, 1'b0, 1'b1}));
      chk("rd_lat", 32'(lat), 32'd6);
      chk("rd_data", 32'(rd), 32'hA5);
      chk("rd_tmo", 32'(tmo), 32'd0);
      settle();

      // timeout
      c0 = resp_cnt;
      run(1'b0, 1'b1, 16'hBFFD, 8'h00, 0, 8'h00, lat, rd, tmo, snap);
      chk("tmo_lat", 32'(lat), 32'd11);
      chk("tmo_data", 32'(rd), 32'hFF);
      chk("tmo_flag", 32'(tmo), 32'd1);
      settle();
      repeat (5) @(posedge clk); #1;
      chk("tmo_single_pulse", 32'(resp_cnt - c0), 32'd1);

      // tie: ready on the final sample
      run(1'b0, 1'b1, 16'hBFFD, 8'h00, T, 8'h3C, lat, rd, tmo, snap);
      chk("tie_lat", 32'(lat), 32'd11);
      chk("tie_data", 32'(rd), 32'h3C);
      chk("tie_tmo", 32'(tmo), 32'd0);
      settle();

      // I/O read answered in the strobe cycle
      run(1'b0, 1'b0, 16'h0098, 8'h00, 1, 8'h5A, lat, rd, tmo, snap);
      chk("io_rd_strobe", 32'(snap), 32'({16'h0098, 8'h00, 1'b1, 1'b0, 1'b0}));
      chk("io_rd_lat", 32'(lat), 32'd2);
      chk("io_rd_data", 32'(rd), 32'h5A);
      settle();

      // stray ready during a write strobe, then during GAP and IDLE
      c0 = resp_cnt;
      run(1'b1, 1'b0, 16'h00F0, 8'h81, 1, 8'hEE, lat, rd, tmo, snap);
      chk("wr_stray_lat", 32'(lat), 32'd1);
      chk("wr_stray_rdata", 32'(rd), 32'h5A);
      bus_read_ready = 1'b1; bus_read_data = 8'hEE;
      repeat (2) @(posedge clk); #1;
      bus_read_ready = 1'b0; bus_read_data = 8'h00;
      settle();
      bus_read_ready = 1'b1; bus_read_data = 8'hEE;
      @(posedge clk); #1;
      bus_read_ready = 1'b0; bus_read_data = 8'h00;
      chk("stray_no_resp", 32'(resp_cnt - c0), 32'd1);
      run(1'b0, 1'b1, 16'h1234, 8'h00, 3, 8'h42, lat, rd, tmo, snap);
      chk("after_stray_lat", 32'(lat), 32'd4);
      chk("after_stray_data", 32'(rd), 32'h42);
      settle();

      // back-to-back with req_valid held high
      c0 = resp_cnt;
      req_valid = 1'b1;
      for (int r = 0; r < 3; r++) begin
         bit ok;
         ok = 1'b0;
         req_write   = (r != 1);
         req_memory  = (r != 0);
         req_address = 16'h0010 + 16'(r);
         req_wdata   = 8'h11 + 8'(r);
         for (int i = 0; i < 60 && !ok; i++) begin
            if (req_ready) ok = 1'b1;
            @(posedge clk); #1;
         end
         chk("b2b_accept", 32'(ok), 32'd1);
         acc_t[r] = tb_cyc;
         mem_s[r] = bus_memory;
      end
      req_valid = 1'b0;
      repeat (25) @(posedge clk); #1;
      chk("b2b_mem", 32'({mem_s[0], mem_s[1], mem_s[2]}), 32'b011);
      chk("b2b_gap_wr", 32'(acc_t[1] - acc_t[0]), 32'd6);
      chk("b2b_gap_rd", 32'(acc_t[2] - acc_t[1]), 32'd16);
      chk("b2b_resp_cnt", 32'(resp_cnt - c0), 32'd3);

      // reset during WAIT
      req_valid = 1'b1; req_write = 1'b0; req_memory = 1'b1; req_address = 16'hA000;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3;
      c0 = resp_cnt;
      n_reset = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(req_ready), 32'd1);
      chk("mid_rst_resp", 32'({resp_valid, resp_timeout, resp_rdata}), 32'd0);
      chk("mid_rst_bus", 32'({bus_address, bus_write_data, bus_read, bus_write, bus_memory}), 32'd0);
      repeat (2) @(posedge clk);
      #3 n_reset = 1'b1;
      repeat (15) @(posedge clk); #1;
      chk("mid_rst_no_resp", 32'(resp_cnt - c0), 32'd0);
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      run(1'b0, 1'b1, 16'hA000, 8'h00, 2, 8'h77, lat, rd, tmo, snap);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_data", 32'(rd), 32'h77);
      chk("post_rst_tmo", 32'(tmo), 32'd0);
      settle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation did not complete in time");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
